// File: rtl/mem_access_unit.sv
// Memory-stage access unit: sequences one lw/sw per instruction over the data SRAM handshake.
// Define ADDR_ALIGN_CHECK_EN to abort misaligned word accesses with addr_err instead of masking the address.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [31:0] mem_addr,
  input  logic [31:0] store_data,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic [31:0] load_data,
  output logic        mem_done,
  output logic        stall,
  output logic        bus_err,
  output logic        addr_err
);

  localparam int unsigned CNT_W       = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [31:0]      r_load_data;
  logic [31:0]      w_load_data_nxt;
  logic             r_bus_err;
  logic             w_bus_err_nxt;
  logic             w_mem_op;
  logic             w_timeout;
  logic [31:0]      w_req_addr;
`ifdef ADDR_ALIGN_CHECK_EN
  logic             r_addr_err;
  logic             w_addr_err_nxt;
  logic             w_misaligned;
`endif

  assign w_mem_op  = is_load | is_store;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_timeout = (w_cnt_inc == TIMEOUT_CNT);

`ifdef ADDR_ALIGN_CHECK_EN
  assign w_misaligned = (mem_addr[1:0] != 2'b00);
  assign w_req_addr   = mem_addr;
`else
  // Word-only bus: low address bits are always presented as zero.
  assign w_req_addr   = {mem_addr[31:2], mem_addr[1:0] & 2'b00};
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_load_data <= '0;
      r_bus_err   <= 1'b0;
`ifdef ADDR_ALIGN_CHECK_EN
      r_addr_err  <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_load_data <= w_load_data_nxt;
      r_bus_err   <= w_bus_err_nxt;
`ifdef ADDR_ALIGN_CHECK_EN
      r_addr_err  <= w_addr_err_nxt;
`endif
    end
  end

  // Next-state, datapath update and SRAM request outputs.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_load_data_nxt = r_load_data;
    w_bus_err_nxt   = r_bus_err;
`ifdef ADDR_ALIGN_CHECK_EN
    w_addr_err_nxt  = r_addr_err;
`endif
    data_sram_req   = 1'b0;
    data_sram_wr    = 1'b0;
    data_sram_wen   = 4'b0000;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    mem_done        = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_bus_err_nxt  = 1'b0;
`ifdef ADDR_ALIGN_CHECK_EN
        w_addr_err_nxt = 1'b0;
`endif
        if (mem_valid && w_mem_op) begin
`ifdef ADDR_ALIGN_CHECK_EN
          if (w_misaligned) begin
            w_state_nxt     = S_DONE;
            w_addr_err_nxt  = 1'b1;
            w_load_data_nxt = 32'h0;
          end else begin
            w_state_nxt = S_REQ;
            w_cnt_nxt   = '0;
          end
`else
          w_state_nxt = S_REQ;
          w_cnt_nxt   = '0;
`endif
        end else if (mem_valid) begin
          mem_done = 1'b1;
        end
      end

      S_REQ: begin
        data_sram_req   = 1'b1;
        data_sram_wr    = is_store;
        data_sram_wen   = is_store ? 4'b1111 : 4'b0000;
        data_sram_addr  = w_req_addr;
        data_sram_wdata = store_data;
        w_cnt_nxt       = w_cnt_inc;
        if (data_sram_addr_ok && data_sram_data_ok) begin
          w_state_nxt = S_DONE;
          if (is_load) w_load_data_nxt = data_sram_rdata;
        end else if (w_timeout) begin
          w_state_nxt     = S_DONE;
          w_bus_err_nxt   = 1'b1;
          w_load_data_nxt = 32'h0;
        end else if (data_sram_addr_ok) begin
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        w_cnt_nxt = w_cnt_inc;
        // A completion landing on the timeout cycle still counts as success.
        if (data_sram_data_ok) begin
          w_state_nxt = S_DONE;
          if (is_load) w_load_data_nxt = data_sram_rdata;
        end else if (w_timeout) begin
          w_state_nxt     = S_DONE;
          w_bus_err_nxt   = 1'b1;
          w_load_data_nxt = 32'h0;
        end
      end

      S_DONE: begin
        mem_done    = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign load_data = r_load_data;
  assign stall     = mem_valid & ~mem_done;
  assign bus_err   = (r_state == S_DONE) & r_bus_err;
`ifdef ADDR_ALIGN_CHECK_EN
  assign addr_err  = (r_state == S_DONE) & r_addr_err;
`else
  assign addr_err  = 1'b0;
`endif

endmodule
